// File: rtl/gate_pool_arbiter.sv
// Round-robin gate allocator: hands free pool gates to N_CH requesters.
// Ports: clk/rst, i_pool_lock, i_req, i_release -> o_grant, o_gates_idx,
//   o_held, o_owned, o_full, o_job_done, o_err (sticky protocol error).
module gate_pool_arbiter #(
  parameter int POOL_WIDTH = 32,
  parameter int N_CH       = 2,
  parameter int IDX_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [POOL_WIDTH-1:0]   i_pool_lock,
  input  logic [N_CH-1:0]         i_req,
  input  logic [N_CH-1:0]         i_release,
  output logic [N_CH-1:0]         o_grant,
  output logic [N_CH*IDX_W-1:0]   o_gates_idx,
  output logic [N_CH-1:0]         o_held,
  output logic [POOL_WIDTH-1:0]   o_owned,
  output logic                    o_full,
  output logic                    o_job_done,
  output logic                    o_err
);

  localparam int SW = $clog2(POOL_WIDTH);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_WAIT,
    ST_HELD
  } st_e;

  st_e             st_q   [N_CH];
  st_e             st_d   [N_CH];
  logic [SW-1:0]   slot_q [N_CH];
  logic [SW-1:0]   slot_d [N_CH];

  logic [CW-1:0]         ch_ptr_q, ch_ptr_d;
  logic [SW-1:0]         sl_ptr_q, sl_ptr_d;
  logic [POOL_WIDTH-1:0] owned_q, owned_d;
  logic [N_CH-1:0]       grant_q, grant_d;
  logic                  err_q, err_d;

  logic [POOL_WIDTH-1:0] free;
  logic [N_CH-1:0]       elig;
  logic                  found_ch, found_sl;
  logic [CW-1:0]         gnt_ch;
  logic [SW-1:0]         gnt_sl;

  assign free   = ~i_pool_lock & ~owned_q;
  assign o_full = ~|free;

  // A HELD channel never competes; FREE and WAIT both follow i_req.
  always_comb begin
    elig = '0;
    for (int k = 0; k < N_CH; k++) begin
      elig[k] = i_req[k] && (st_q[k] != ST_HELD);
    end
  end

  // Pick the eligible channel with the smallest distance from ch_ptr.
  always_comb begin
    int best;
    int d;
    best   = N_CH;
    d      = 0;
    gnt_ch = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (elig[c]) begin
        d = c - int'(ch_ptr_q);
        if (d < 0) d = d + N_CH;
        if (d < best) begin
          best   = d;
          gnt_ch = CW'(c);
        end
      end
    end
    found_ch = (best < N_CH);
  end

  // Same distance trick for the first free gate at/after slot_ptr.
  always_comb begin
    int best;
    int d;
    best   = POOL_WIDTH;
    d      = 0;
    gnt_sl = '0;
    for (int s = 0; s < POOL_WIDTH; s++) begin
      if (free[s]) begin
        d = s - int'(sl_ptr_q);
        if (d < 0) d = d + POOL_WIDTH;
        if (d < best) begin
          best   = d;
          gnt_sl = SW'(s);
        end
      end
    end
    found_sl = (best < POOL_WIDTH);
  end

  always_comb begin
    owned_d  = owned_q;
    grant_d  = '0;
    err_d    = err_q;
    ch_ptr_d = ch_ptr_q;
    sl_ptr_d = sl_ptr_q;
    for (int k = 0; k < N_CH; k++) begin
      st_d[k]   = st_q[k];
      slot_d[k] = slot_q[k];
    end
    for (int k = 0; k < N_CH; k++) begin
      unique case (st_q[k])
        ST_FREE: begin
          if (i_release[k]) err_d = 1'b1;
          if (i_req[k]) st_d[k] = ST_WAIT;
        end
        ST_WAIT: begin
          if (i_release[k]) err_d = 1'b1;
          if (!i_req[k]) st_d[k] = ST_FREE;
        end
        ST_HELD: begin
          if (i_req[k]) err_d = 1'b1;
          if (i_release[k]) begin
            st_d[k]             = ST_FREE;
            owned_d[slot_q[k]]  = 1'b0;
          end
        end
        default: st_d[k] = ST_FREE;
      endcase
    end
    // free is built from owned_q, so a gate released this cycle
    // cannot be handed out again until the next one.
    if (found_ch && found_sl) begin
      grant_d[gnt_ch] = 1'b1;
      st_d[gnt_ch]    = ST_HELD;
      slot_d[gnt_ch]  = gnt_sl;
      owned_d[gnt_sl] = 1'b1;
      if (int'(gnt_ch) == N_CH - 1) ch_ptr_d = '0;
      else ch_ptr_d = CW'(int'(gnt_ch) + 1);
      if (int'(gnt_sl) == POOL_WIDTH - 1) sl_ptr_d = '0;
      else sl_ptr_d = SW'(int'(gnt_sl) + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owned_q  <= '0;
      grant_q  <= '0;
      err_q    <= 1'b0;
      ch_ptr_q <= '0;
      sl_ptr_q <= '0;
      for (int k = 0; k < N_CH; k++) begin
        st_q[k]   <= ST_FREE;
        slot_q[k] <= '0;
      end
    end else begin
      owned_q  <= owned_d;
      grant_q  <= grant_d;
      err_q    <= err_d;
      ch_ptr_q <= ch_ptr_d;
      sl_ptr_q <= sl_ptr_d;
      for (int k = 0; k < N_CH; k++) begin
        st_q[k]   <= st_d[k];
        slot_q[k] <= slot_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      o_held[k] = (st_q[k] == ST_HELD);
      o_gates_idx[k*IDX_W +: IDX_W] =
        o_held[k] ? IDX_W'(slot_q[k]) : {IDX_W{1'b1}};
    end
  end

  assign o_grant    = grant_q;
  assign o_owned    = owned_q;
  assign o_err      = err_q;
  assign o_job_done = &o_held;

endmodule

// File: tb/tb_gate_pool_arbiter.sv
// Directed bench for gate_pool_arbiter: a 32-gate and a 4-gate instance.
// Each task drives one scenario and checks hand-computed values inline.
module tb_gate_pool_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-gate instance
  logic [31:0] lock;
  logic [1:0]  req, rel;
  logic [1:0]  grant, held;
  logic [63:0] gidx;
  logic [31:0] owned;
  logic        full, jdone, err;

  // 4-gate instance
  logic [3:0]  lock4;
  logic [1:0]  req4, rel4;
  logic [1:0]  grant4, held4;
  logic [63:0] gidx4;
  logic [3:0]  owned4;
  logic        full4, jdone4, err4;

  int n_cmp = 0;
  int n_err = 0;

  gate_pool_arbiter #(.POOL_WIDTH(32), .N_CH(2), .IDX_W(32)) u_dut (
    .clk(clk), .rst(rst), .i_pool_lock(lock), .i_req(req),
    .i_release(rel), .o_grant(grant), .o_gates_idx(gidx),
    .o_held(held), .o_owned(owned), .o_full(full),
    .o_job_done(jdone), .o_err(err)
  );

  gate_pool_arbiter #(.POOL_WIDTH(4), .N_CH(2), .IDX_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .i_pool_lock(lock4), .i_req(req4),
    .i_release(rel4), .o_grant(grant4), .o_gates_idx(gidx4),
    .o_held(held4), .o_owned(owned4), .o_full(full4),
    .o_job_done(jdone4), .o_err(err4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 0; rel = 0; req4 = 0; rel4 = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    lock = 32'h0; lock4 = 4'h0;
    do_reset();
    n_cmp++; if (owned !== 32'h0) begin n_err++; $display("FAIL rst_owned: got %h want 0", owned); end
    n_cmp++; if (held !== 2'b00) begin n_err++; $display("FAIL rst_held: got %b want 00", held); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL rst_grant: got %b want 00", grant); end
    n_cmp++; if (gidx !== {64{1'b1}}) begin n_err++; $display("FAIL rst_idx: got %h want all ones", gidx); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (full !== 1'b0 || jdone !== 1'b0) begin n_err++; $display("FAIL rst_full_done: got %b%b want 00", full, jdone); end
  endtask

  task automatic test_single_free();
    do_reset();
    lock = 32'hFFFF_FFFE; req = 2'b01;
    tick();
    req = 2'b00;
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b want 01", grant); end
    n_cmp++; if (gidx[31:0] !== 32'd0) begin n_err++; $display("FAIL single_idx: got %h want 0", gidx[31:0]); end
    n_cmp++; if (owned !== 32'h1) begin n_err++; $display("FAIL single_owned: got %h want 1", owned); end
    n_cmp++; if (full !== 1'b1 || jdone !== 1'b0) begin n_err++; $display("FAIL single_full_done: got %b%b want 10", full, jdone); end
    tick();
    n_cmp++; if (grant !== 2'b00 || held !== 2'b01) begin n_err++; $display("FAIL single_pulse: got grant %b held %b want 00 01", grant, held); end
    // Lock rising on an owned gate must not revoke it.
    lock = 32'hFFFF_FFFF;
    tick();
    n_cmp++; if (held !== 2'b01 || owned !== 32'h1) begin n_err++; $display("FAIL lock_keep: got held %b owned %h want 01 1", held, owned); end
    rel = 2'b01;
    tick();
    rel = 2'b00;
    n_cmp++; if (held !== 2'b00 || owned !== 32'h0 || gidx[31:0] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL single_rel: got held %b owned %h idx %h want 00 0 ffffffff", held, owned, gidx[31:0]); end
  endtask

  task automatic test_two_channels();
    do_reset();
    lock = 32'h0; req = 2'b11;
    tick();
    req = 2'b10;
    n_cmp++; if (grant !== 2'b01 || gidx[31:0] !== 32'd0) begin n_err++; $display("FAIL two_c1: got grant %b idx0 %h want 01 0", grant, gidx[31:0]); end
    n_cmp++; if (jdone !== 1'b0) begin n_err++; $display("FAIL two_done1: got %b want 0", jdone); end
    tick();
    req = 2'b00;
    n_cmp++; if (grant !== 2'b10 || gidx[63:32] !== 32'd1) begin n_err++; $display("FAIL two_c2: got grant %b idx1 %h want 10 1", grant, gidx[63:32]); end
    n_cmp++; if (jdone !== 1'b1 || owned !== 32'h3) begin n_err++; $display("FAIL two_done2: got done %b owned %h want 1 3", jdone, owned); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL two_err: got %b want 0", err); end
  endtask

  task automatic test_pool_full();
    do_reset();
    lock4 = 4'b0111; req4 = 2'b01;
    tick();
    req4 = 2'b10;
    n_cmp++; if (grant4 !== 2'b01 || gidx4[31:0] !== 32'd3) begin n_err++; $display("FAIL full_c0: got grant %b idx %h want 01 3", grant4, gidx4[31:0]); end
    tick();
    tick();
    n_cmp++; if (grant4 !== 2'b00 || full4 !== 1'b1 || held4 !== 2'b01) begin n_err++; $display("FAIL full_wait: got grant %b full %b held %b want 00 1 01", grant4, full4, held4); end
    rel4 = 2'b01;
    tick();
    rel4 = 2'b00;
    n_cmp++; if (grant4 !== 2'b00 || gidx4[31:0] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL full_rel: got grant %b idx0 %h want 00 ffffffff", grant4, gidx4[31:0]); end
    tick();
    req4 = 2'b00;
    n_cmp++; if (grant4 !== 2'b10 || gidx4[63:32] !== 32'd3) begin n_err++; $display("FAIL full_regrant: got grant %b idx1 %h want 10 3", grant4, gidx4[63:32]); end
  endtask

  task automatic test_wrap();
    do_reset();
    lock4 = 4'b1011; req4 = 2'b01;
    tick();
    req4 = 2'b00;
    n_cmp++; if (gidx4[31:0] !== 32'd2) begin n_err++; $display("FAIL wrap_setup: got %h want 2", gidx4[31:0]); end
    rel4 = 2'b01;
    tick();
    rel4 = 2'b00;
    // slot_ptr=3, ch_ptr=1: idx3 locked so search wraps to 0, ch1 wins.
    lock4 = 4'b1000; req4 = 2'b11;
    tick();
    req4 = 2'b01;
    n_cmp++; if (grant4 !== 2'b10 || gidx4[63:32] !== 32'd0) begin n_err++; $display("FAIL wrap_idx: got grant %b idx1 %h want 10 0", grant4, gidx4[63:32]); end
    tick();
    req4 = 2'b00;
    n_cmp++; if (grant4 !== 2'b01 || gidx4[31:0] !== 32'd1) begin n_err++; $display("FAIL wrap_next: got grant %b idx0 %h want 01 1", grant4, gidx4[31:0]); end
  endtask

  task automatic test_err();
    do_reset();
    lock = 32'h0; rel = 2'b10;
    tick();
    rel = 2'b00;
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err); end
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    n_cmp++; if (err !== 1'b1 || held !== 2'b01) begin n_err++; $display("FAIL err_sticky: got err %b held %b want 1 01", err, held); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (err !== 1'b0 || gidx !== {64{1'b1}}) begin n_err++; $display("FAIL err_clear: got err %b idx %h want 0 all ones", err, gidx); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    lock = 32'h0; req = 2'b01; rst = 1'b1;
    tick();
    rst = 1'b0; req = 2'b00;
    n_cmp++; if (grant !== 2'b00 || owned !== 32'h0 || held !== 2'b00) begin n_err++; $display("FAIL rst_mid: got grant %b owned %h held %b want 00 0 00", grant, owned, held); end
    tick();
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL rst_mid_late: got %b want 00", grant); end
  endtask

  initial begin
    lock = 0; req = 0; rel = 0; lock4 = 0; req4 = 0; rel4 = 0;
    test_reset();
    test_single_free();
    test_two_channels();
    test_pool_full();
    test_wrap();
    test_err();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
